// File: rtl/trigger_frame_arbiter.sv
// Frame-level round-robin arbiter merging CH_NUM trigger frame streams into one AXI4-Stream; polices oversize frames.
// Define TRIGGER_ARB_CH_ID_EN to add M_AXIS_TUSER carrying the granted channel index on every beat.
module trigger_frame_arbiter #(
    parameter int unsigned CH_NUM          = 4,
    parameter int unsigned TDATA_WIDTH     = 256,
    parameter int unsigned MAX_FRAME_BEATS = 64
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          STOP,
    input  logic                          ERR_CLEAR,
    input  logic [CH_NUM*TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [CH_NUM-1:0]             S_AXIS_TVALID,
    input  logic [CH_NUM-1:0]             S_AXIS_TLAST,
    output logic [CH_NUM-1:0]             S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]        M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    output logic                          M_AXIS_TLAST,
`ifdef TRIGGER_ARB_CH_ID_EN
    output logic [$clog2(CH_NUM)-1:0]     M_AXIS_TUSER,
`endif
    input  logic                          M_AXIS_TREADY,
    output logic [CH_NUM-1:0]             GRANT,
    output logic                          BUSY,
    output logic [CH_NUM-1:0]             OVERSIZE_ERR
);

    localparam int unsigned IDX_W = $clog2(CH_NUM);
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(MAX_FRAME_BEATS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CH_NUM-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [TDATA_WIDTH-1:0] mdata_q, mdata_d;
    logic                   mvalid_q, mvalid_d;
    logic                   mlast_q, mlast_d;
    logic                   busy_q, busy_d;
    logic [CH_NUM-1:0]      err_q, err_d;
    logic [CH_NUM-1:0]      err_set;
`ifdef TRIGGER_ARB_CH_ID_EN
    logic [IDX_W-1:0]       tuser_q, tuser_d;
`endif

    logic [SUM_W-1:0]       cand;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;
    logic [31:0]            data_base;
    logic [TDATA_WIDTH-1:0] s_data_g;
    logic                   s_valid_g;
    logic                   s_last_g;
    logic                   out_free;
    logic                   tready_g;
    logic                   accept;
    logic                   at_max;
    logic [IDX_W-1:0]       next_ptr;

    // Round-robin search: descending loop so the channel closest to rr_ptr wins
    always_comb begin
        cand     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            cand = SUM_W'(rr_ptr_q) + SUM_W'(i);
            if (cand >= SUM_W'(CH_NUM)) begin
                cand = cand - SUM_W'(CH_NUM);
            end
            if (S_AXIS_TVALID[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign data_base = 32'(idx_q) * TDATA_WIDTH;
    assign s_data_g  = S_AXIS_TDATA[data_base +: TDATA_WIDTH];
    assign s_valid_g = S_AXIS_TVALID[idx_q];
    assign s_last_g  = S_AXIS_TLAST[idx_q];

    // FLUSH drains the source regardless of the output slice
    assign out_free      = ~mvalid_q | M_AXIS_TREADY;
    assign tready_g      = ((state_q == ST_GRANT) & out_free) | (state_q == ST_FLUSH);
    assign S_AXIS_TREADY = tready_g ? grant_q : '0;
    assign accept        = s_valid_g & tready_g;
    assign at_max        = (beat_cnt_q == CNT_W'(MAX_FRAME_BEATS - 1));
    assign next_ptr      = (idx_q == IDX_W'(CH_NUM - 1)) ? '0 : idx_q + IDX_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        mdata_d    = mdata_q;
        mvalid_d   = mvalid_q;
        mlast_d    = mlast_q;
        busy_d     = busy_q;
        err_set    = '0;
`ifdef TRIGGER_ARB_CH_ID_EN
        tuser_d    = tuser_q;
`endif
        if (M_AXIS_TREADY) begin
            mvalid_d = 1'b0;
            mlast_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!STOP && pick_vld) begin
                    state_d    = ST_GRANT;
                    grant_d    = CH_NUM'(1) << pick_idx;
                    idx_d      = pick_idx;
                    beat_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    mdata_d    = s_data_g;
                    mvalid_d   = 1'b1;
                    mlast_d    = s_last_g | at_max;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
`ifdef TRIGGER_ARB_CH_ID_EN
                    tuser_d    = idx_q;
`endif
                    if (s_last_g) begin
                        rr_ptr_d = next_ptr;
                        grant_d  = '0;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (at_max) begin
                        err_set = grant_q;
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (accept && s_last_g) begin
                    rr_ptr_d = next_ptr;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        // A new oversize event beats a simultaneous clear
        err_d = (err_q & ~{CH_NUM{ERR_CLEAR}}) | err_set;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            mdata_q    <= '0;
            mvalid_q   <= 1'b0;
            mlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= '0;
`ifdef TRIGGER_ARB_CH_ID_EN
            tuser_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            mdata_q    <= mdata_d;
            mvalid_q   <= mvalid_d;
            mlast_q    <= mlast_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
`ifdef TRIGGER_ARB_CH_ID_EN
            tuser_q    <= tuser_d;
`endif
        end
    end

    assign M_AXIS_TDATA  = mdata_q;
    assign M_AXIS_TVALID = mvalid_q;
    assign M_AXIS_TLAST  = mlast_q;
    assign GRANT         = grant_q;
    assign BUSY          = busy_q;
    assign OVERSIZE_ERR  = err_q;
`ifdef TRIGGER_ARB_CH_ID_EN
    assign M_AXIS_TUSER  = tuser_q;
`endif

endmodule

// File: tb/tb_trigger_frame_arbiter.sv
// Directed bench for trigger_frame_arbiter: single frame, round robin, backpressure, oversize, STOP, mid-frame reset.
// Beat payload encodes {channel, frame id, beat index} so order, origin and drops are visible on the output.
module tb_trigger_frame_arbiter;

    localparam int unsigned CH   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXB = 64;
    localparam int unsigned IW   = 2;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              STOP;
    logic              ERR_CLEAR;
    logic [CH*DW-1:0]  s_tdata;
    logic [CH-1:0]     s_tvalid;
    logic [CH-1:0]     s_tlast;
    logic [CH-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [CH-1:0]     grant;
    logic              busy;
    logic [CH-1:0]     oversize;
`ifdef TRIGGER_ARB_CH_ID_EN
    logic [IW-1:0]     m_tuser;
`endif

    int rem [CH];
    int pos [CH];
    int nfr [CH];
    int flen[CH];
    int fid [CH];
    logic [DW:0] oq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;

    always #5 ACLK = ~ACLK;

    trigger_frame_arbiter #(
        .CH_NUM(CH), .TDATA_WIDTH(DW), .MAX_FRAME_BEATS(MAXB)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .STOP(STOP), .ERR_CLEAR(ERR_CLEAR),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
`ifdef TRIGGER_ARB_CH_ID_EN
        .M_AXIS_TUSER(m_tuser),
`endif
        .M_AXIS_TREADY(m_tready),
        .GRANT(grant), .BUSY(busy), .OVERSIZE_ERR(oversize)
    );

    function automatic logic [DW-1:0] mk(int ch, int fr, int b);
        return {4'(ch), 12'(fr), 16'(b)};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int k = 0; k < int'(CH); k++) begin
            s_tvalid[k]          = (rem[k] > 0);
            s_tlast[k]           = (rem[k] == 1);
            s_tdata[k*DW +: DW]  = mk(k, fid[k], pos[k]);
        end
    endtask

    task automatic load(int k, int len, int n, int f0);
        flen[k] = len;
        nfr[k]  = n - 1;
        rem[k]  = len;
        pos[k]  = 0;
        fid[k]  = f0;
        drive_src();
    endtask

    task automatic clear_src();
        for (int k = 0; k < int'(CH); k++) begin
            rem[k] = 0; pos[k] = 0; nfr[k] = 0; flen[k] = 0; fid[k] = 0;
        end
        drive_src();
    endtask

    function automatic logic src_busy();
        for (int k = 0; k < int'(CH); k++) if (rem[k] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: handshakes sampled just before the edge, sources and scoreboard updated after it
    task automatic step();
        logic [CH-1:0] hs;
        logic          mhs;
        logic          hold;
        logic [DW-1:0] hd;
        logic          hl;
`ifdef TRIGGER_ARB_CH_ID_EN
        logic [IW-1:0] hu;
`endif
        m_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        #1;
        hs   = s_tvalid & s_tready;
        mhs  = m_tvalid & m_tready;
        hold = m_tvalid & ~m_tready;
        hd   = m_tdata;
        hl   = m_tlast;
`ifdef TRIGGER_ARB_CH_ID_EN
        hu   = m_tuser;
`endif
        @(posedge ACLK);
        #1;
        cyc++;
        if (mhs === 1'b1) begin
            oq.push_back({hl, hd});
`ifdef TRIGGER_ARB_CH_ID_EN
            chk("tuser", 64'(hu), 64'(hd[31:28]));
`endif
        end
        if (hold === 1'b1) begin
            chk("hold_valid", 64'(m_tvalid), 64'(1));
            chk("hold_data", 64'(m_tdata), 64'(hd));
        end
        for (int k = 0; k < int'(CH); k++) begin
            if (hs[k] === 1'b1) begin
                pos[k]++;
                rem[k]--;
                if (rem[k] == 0 && nfr[k] > 0) begin
                    nfr[k]--;
                    fid[k]++;
                    rem[k] = flen[k];
                    pos[k] = 0;
                end
            end
        end
        drive_src();
    endtask

    task automatic run_idle(string tag, int maxc);
        int n = 0;
        while ((src_busy() || busy || m_tvalid) && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < maxc), 64'(1));
    endtask

    task automatic check_frame(string tag, int ch, int fr, int len);
        logic [DW:0] e;
        chk({tag, "_beats"}, 64'(oq.size() >= len), 64'(1));
        for (int i = 0; i < len && oq.size() > 0; i++) begin
            e = oq.pop_front();
            chk({tag, "_data"}, 64'(e[DW-1:0]), 64'(mk(ch, fr, i)));
            chk({tag, "_last"}, 64'(e[DW]), 64'(i == len - 1));
        end
    endtask

    initial begin
        ARESET = 1'b1; STOP = 1'b0; ERR_CLEAR = 1'b0; m_tready = 1'b1;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0;
        clear_src();
        step(); step();
        ARESET = 1'b0;
        step();
        chk("rst_mvalid", 64'(m_tvalid), 64'(0));
        chk("rst_mlast", 64'(m_tlast), 64'(0));
        chk("rst_mdata", 64'(m_tdata), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sready", 64'(s_tready), 64'(0));
        chk("rst_err", 64'(oversize), 64'(0));

        // Single 5-beat frame on ch0: first output beat two cycles after TVALID
        load(0, 5, 1, 0);
        step();
        chk("s1_grant", 64'(grant), 64'(4'b0001));
        chk("s1_busy", 64'(busy), 64'(1));
        chk("s1_bubble", 64'(m_tvalid), 64'(0));
        step();
        chk("s1_first_valid", 64'(m_tvalid), 64'(1));
        chk("s1_first_data", 64'(m_tdata), 64'(mk(0, 0, 0)));
        chk("s1_first_last", 64'(m_tlast), 64'(0));
        run_idle("s1", 100);
        check_frame("s1", 0, 0, 5);
        chk("s1_grant_idle", 64'(grant), 64'(0));
        chk("s1_q", 64'(oq.size()), 64'(0));

        // Round robin from rr_ptr=1: all channels hold two 3-beat frames
        load(0, 3, 2, 10); load(1, 3, 2, 10); load(2, 3, 2, 10); load(3, 3, 2, 10);
        run_idle("rr", 500);
        check_frame("rr1", 1, 10, 3);
        check_frame("rr2", 2, 10, 3);
        check_frame("rr3", 3, 10, 3);
        check_frame("rr0", 0, 10, 3);
        check_frame("rr1b", 1, 11, 3);
        check_frame("rr2b", 2, 11, 3);
        check_frame("rr3b", 3, 11, 3);
        check_frame("rr0b", 0, 11, 3);
        chk("rr_q", 64'(oq.size()), 64'(0));

        // Backpressure 1,0,0,1 on an 8-beat ch1 frame
        rdy_mode = 1;
        load(1, 8, 1, 20);
        run_idle("bp", 300);
        rdy_mode = 0;
        check_frame("bp", 1, 20, 8);
        chk("bp_q", 64'(oq.size()), 64'(0));

        // Oversize: ch2 sends 70 beats, ch3 waiting with 3 beats
        load(2, 70, 1, 30); load(3, 3, 1, 30);
        run_idle("ov", 600);
        check_frame("ov2", 2, 30, 64);
        check_frame("ov3", 3, 30, 3);
        chk("ov_q", 64'(oq.size()), 64'(0));
        chk("ov_err", 64'(oversize), 64'(4'b0100));
        chk("ov_flushed", 64'(rem[2]), 64'(0));
        ERR_CLEAR = 1'b1;
        step();
        ERR_CLEAR = 1'b0;
        chk("ov_clear", 64'(oversize), 64'(0));

        // Exactly MAX_FRAME_BEATS beats is legal
        load(0, 64, 1, 40);
        run_idle("ex", 600);
        check_frame("ex", 0, 40, 64);
        chk("ex_err", 64'(oversize), 64'(0));
        chk("ex_q", 64'(oq.size()), 64'(0));

        // STOP mid-frame on ch1 while ch2 is pending
        load(1, 4, 1, 50); load(2, 3, 1, 50);
        step();
        chk("st_grant1", 64'(grant), 64'(4'b0010));
        step(); step();
        STOP = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("st_busy", 64'(busy), 64'(0));
        chk("st_grant_idle", 64'(grant), 64'(0));
        chk("st_pending", 64'(rem[2]), 64'(3));
        check_frame("st1", 1, 50, 4);
        STOP = 1'b0;
        step();
        chk("st_grant2", 64'(grant), 64'(4'b0100));
        step();
        chk("st_first_valid", 64'(m_tvalid), 64'(1));
        chk("st_first_data", 64'(m_tdata), 64'(mk(2, 50, 0)));
        run_idle("st", 100);
        check_frame("st2", 2, 50, 3);
        chk("st_q", 64'(oq.size()), 64'(0));

        // Reset mid-frame on ch3, then arbitration restarts at ch0
        load(3, 6, 1, 60);
        step(); step(); step(); step();
        ARESET = 1'b1;
        clear_src();
        step();
        chk("mr_mvalid", 64'(m_tvalid), 64'(0));
        chk("mr_mlast", 64'(m_tlast), 64'(0));
        chk("mr_mdata", 64'(m_tdata), 64'(0));
        chk("mr_grant", 64'(grant), 64'(0));
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_sready", 64'(s_tready), 64'(0));
        ARESET = 1'b0;
        oq.delete();
        load(1, 2, 1, 70); load(3, 2, 1, 71);
        step();
        chk("mr_grant_ch1", 64'(grant), 64'(4'b0010));
        run_idle("mr", 100);
        check_frame("mr1", 1, 70, 2);
        check_frame("mr3", 3, 71, 2);
        chk("mr_q", 64'(oq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
